// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//
// Registered N-to-2^N one-hot decoder with enable and two operating modes:
//   direct : a handshaked address is decoded and held on Y
//   scan   : Y walks through every output in turn, DWELL cycles per output,
//            for row/column strobe and select-line sequencing
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   e_i         enable; 0 forces Y inactive and Y_VALID low
//   mode_i      0 = direct decode, 1 = scan
//   a_i         address to decode in direct mode
//   a_valid_i   a_i is valid this cycle
//   a_ready_o   combinational, e_i & ~mode_i
//   y_o         registered one-hot output (polarity set by ACTIVE_LOW)
//   y_valid_o   y_o holds a decoded value
//   scan_idx_o  index currently driven active
//   wrap_o      one-cycle pulse when the scan wraps from 2^N-1 back to 0
//
// Parameters
//   N           address width, output width is 2^N
//   DWELL       cycles each output stays active in scan mode (1 or more)
//   ACTIVE_LOW  1 inverts y_o only (active bit 0, inactive bits 1)
//
// State | meaning
// ------+------------------------------------------------
// IDLE  | outputs inactive, y_valid_o low
// HOLD  | direct-mode address latched and held on y_o
// SCAN  | autonomous sequencing through all outputs
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int unsigned N          = 2,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                e_i,
    input  logic                mode_i,
    input  logic [N-1:0]        a_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    output logic [(1<<N)-1:0]   y_o,
    output logic                y_valid_o,
    output logic [N-1:0]        scan_idx_o,
    output logic                wrap_o
);

    localparam int unsigned W  = 1 << N;
    // Counter only ever needs to reach DWELL-1; sized for DWELL to keep the
    // width at least one bit when DWELL is 1.
    localparam int unsigned CW = $clog2(DWELL + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};
    localparam logic [W-1:0]  Y_INACTIVE = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  idx_q,   idx_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          valid_q, valid_d;
    logic          wrap_q,  wrap_d;
    logic [W-1:0]  y_q,     y_d;

    assign a_ready_o = e_i & ~mode_i;

    // Priority: enable, then mode, then address handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (!e_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (mode_i) begin
            if (state_q != ST_SCAN) begin
                // Scan entry always starts at index 0 and never flags a wrap.
                state_d = ST_SCAN;
                idx_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (a_valid_i) begin
            state_d = ST_HOLD;
            idx_d   = a_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (state_q != ST_HOLD) begin
            // Leaving scan without a new address drops to idle; this branch
            // also steers any unused encoding back to idle.
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end

        // Y is stored already polarised so the output pins come straight
        // from flops.
        if (valid_d) begin
            y_d = (W'(1) << idx_d) ^ Y_INACTIVE;
        end else begin
            y_d = Y_INACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            y_q     <= Y_INACTIVE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y_o        = y_q;
    assign y_valid_o  = valid_q;
    assign scan_idx_o = idx_q;
    assign wrap_o     = wrap_q;

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with an enable input. Successor to the fixed 2-to-4 combinational decoder.
- Two modes:
  - Direct: decodes a handshaked address.
  - Scan: autonomously strobes each output in turn, with a programmable dwell time. Used for row/column strobe and select-line sequencing.
- Outputs are registered. Output polarity is selectable.

Parameters:
- N, 2, address width; the output width is 2^N.
- DWELL, 4, clock cycles each output stays active in scan mode; legal range is 1 or more.
- ACTIVE_LOW, 0, 1 inverts Y only (active bit is 0, inactive bits are 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- E  input  1  enable; 0 forces outputs inactive.
- MODE  input  1  0 = direct decode, 1 = scan.
- A  input  N  address to decode (direct mode).
- A_VALID  input  1  A is valid this cycle.
- A_READY  output  1  combinational; equals E AND NOT MODE.
- Y  output  2^N  registered one-hot decode output.
- Y_VALID  output  1  Y holds a decoded value.
- SCAN_IDX  output  N  index currently driven active.
- WRAP  output  1  one-cycle pulse when a scan wraps from index 2^N-1 to 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- rst=1 sets immediately, without waiting for clk:
  - state IDLE;
  - Y inactive (all 0, or all 1 if ACTIVE_LOW);
  - Y_VALID=0, SCAN_IDX=0, WRAP=0, dwell counter=0.
- rst=1 mid-scan aborts the scan. Operation after release starts from IDLE.
- States:
  - IDLE: Y inactive, Y_VALID=0.
  - HOLD: direct value latched.
  - SCAN: auto-sequencing.
- Priority each cycle: E, then MODE, then A_VALID.
- Any state with E=0: next state IDLE, Y inactive, Y_VALID=0, WRAP=0. A_VALID is ignored (A_READY=0).
- E=1, MODE=1, current state IDLE or HOLD: next state SCAN, SCAN_IDX=0, counter=0, Y=onehot(0), Y_VALID=1.
- E=1, MODE=0, A_VALID=1 (accept), any state: next Y=onehot(A), SCAN_IDX=A, Y_VALID=1, state HOLD. Latency is 1 cycle from accept.
- E=1, MODE=0, A_VALID=0:
  - from HOLD: outputs hold.
  - from IDLE: stays IDLE.
  - from SCAN: goes to IDLE (Y inactive, Y_VALID=0).
- SCAN with E=1, MODE=1:
  - counter increments each cycle.
  - When counter==DWELL-1: counter=0, SCAN_IDX=SCAN_IDX+1 modulo 2^N, Y=onehot(new index).
  - DWELL=1 advances every cycle.
  - Scan period is DWELL*2^N cycles.
- WRAP is registered. It is 1 for exactly the one cycle in which Y first shows index 0 after index 2^N-1, and 0 otherwise. It is never set on scan entry.
- Invariants:
  - Y has at most one active bit at all times.
  - Y_VALID=0 implies Y is fully inactive.
  - SCAN_IDX always matches the active bit when Y_VALID=1.
- ACTIVE_LOW inverts Y only. All other outputs are unaffected.
- No arithmetic overflow: the counter is ceil(log2(DWELL+1)) bits wide, and the index wraps naturally at N bits.

Test Plan:
- Reset. N=2, DWELL=3: pulse rst asynchronously between edges -> Y=0000, Y_VALID=0, SCAN_IDX=0, WRAP=0 immediately, before the next edge.
- Disabled. E=0, MODE=0, A=2'b10, A_VALID=1 for 5 cycles -> A_READY=0, Y stays 0000, Y_VALID=0.
- Direct decode. E=1, MODE=0; accept A=0,1,2,3 on consecutive cycles -> one cycle after each accept, Y=0001, 0010, 0100, 1000, Y_VALID=1. Then A_VALID=0 -> Y holds 1000.
- Scan. E=1, MODE=1, DWELL=3 -> Y=0001 ×3, 0010 ×3, 0100 ×3, 1000 ×3, then 0001 with WRAP=1 for exactly one cycle. Period is 12 cycles, and SCAN_IDX tracks the active bit.
- Interrupt. During scan at SCAN_IDX=2, drop E -> next cycle Y=0000, Y_VALID=0. Raise E again with MODE=1 -> scan restarts at index 0, WRAP=0. In a separate run, assert rst during scan -> immediate clear.
- Polarity and width. N=3, ACTIVE_LOW=1, E=1, MODE=0, accept A=5 -> Y=8'b1101_1111. Drop E -> Y=8'hFF.
